// File: rtl/seq_grid_pkg.sv
// Shared types and helpers for the step-sequencer grid.
package seq_grid_pkg;

   localparam int DISP_DIM = 16;

   typedef logic [DISP_DIM-1:0][DISP_DIM-1:0] pixel_frame_t;

   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_t;

   // Index width for n entries, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/step_quantizer.sv
// Turns the playback position into a clamped, registered step index and
// pulses step_tick whenever that index changes.
module step_quantizer
   import seq_grid_pkg::*;
#(
   parameter int STEPS     = 15,
   parameter int POS_W     = 11,
   parameter int STEP_LEN  = 146,
   localparam int STEP_W   = idx_w(STEPS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [POS_W-1:0]  pos,
   output logic [STEP_W-1:0] step_idx,
   output logic              step_tick
);

   logic [31:0]       quot;
   logic [STEP_W-1:0] step_d, step_q;
   logic              tick_d, tick_q;
   logic              armed_q;   // low on the first cycle after reset, suppresses a spurious tick

   // Divide the position into whole steps; positions past the loop end hold the last step.
   always_comb begin
      quot   = 32'(pos) / 32'(STEP_LEN);
      step_d = (quot >= 32'(STEPS)) ? STEP_W'(STEPS - 1) : STEP_W'(quot);
      tick_d = armed_q && (step_d != step_q);
   end

   // Step register, change pulse and post-reset arming flag.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         step_q  <= '0;
         tick_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         step_q  <= step_d;
         tick_q  <= tick_d;
         armed_q <= 1'b1;
      end
   end

   assign step_idx  = step_q;
   assign step_tick = tick_q;

endmodule

// File: rtl/step_sequencer_grid.sv
// Step-sequencer grid: pattern storage with record/erase/clear, per-row
// gate playback with mute, and the 16x16 red/green LED frame.
module step_sequencer_grid
   import seq_grid_pkg::*;
#(
   parameter int ROWS      = 8,
   parameter int STEPS     = 15,
   parameter int POS_W     = 11,
   parameter int STEP_LEN  = 146,
   localparam int SEL_W    = idx_w(ROWS),
   localparam int STEP_W   = idx_w(STEPS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [POS_W-1:0]  pos,
   input  logic [SEL_W-1:0]  note_sel,
   input  logic              write,
   input  logic              erase,
   input  logic              clear_req,
   input  logic [ROWS-1:0]   mute,
   output logic              busy,
   output logic [ROWS-1:0]   gate_out,
   output logic [STEP_W-1:0] step_idx,
   output logic              step_tick,
   output pixel_frame_t      RedPixels,
   output pixel_frame_t      GrnPixels
);

   clr_state_t                 state_q, state_d;
   logic [SEL_W-1:0]           clr_row_q, clr_row_d;
   logic [ROWS-1:0][STEPS-1:0] pattern_q, pattern_d;
   logic [ROWS-1:0]            gate_q, gate_d;
   pixel_frame_t               red_q, red_d, grn_q, grn_d;
   logic                       sel_ok;

   step_quantizer #(
      .STEPS    (STEPS),
      .POS_W    (POS_W),
      .STEP_LEN (STEP_LEN)
   ) u_quant (
      .clk       (clk),
      .reset     (reset),
      .pos       (pos),
      .step_idx  (step_idx),
      .step_tick (step_tick)
   );

   assign busy   = (state_q == CLEAR);
   assign sel_ok = (int'(note_sel) < ROWS);

   // Clear FSM: sweep one row per cycle from row 0 up, then return to idle.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      state_d   = state_q;
      clr_row_d = clr_row_q;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               clr_row_d = '0;
            end
         end
         CLEAR: begin
            if (int'(clr_row_q) == ROWS - 1) begin
               state_d   = IDLE;
               clr_row_d = '0;
            end else begin
               clr_row_d = clr_row_q + SEL_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pattern update: the clear sweep locks out editing; erase beats write.
   always_comb begin
      pattern_d = pattern_q;
      if (state_q == CLEAR) begin
         pattern_d[clr_row_q] = '0;
      end else if (sel_ok) begin
         if (erase)
            pattern_d[note_sel][step_idx] = 1'b0;
         else if (write)
            pattern_d[note_sel][step_idx] = 1'b1;
      end
   end

   // Gates and LED frames from the current pattern, step, cursor row and mutes.
   always_comb begin
      gate_d = '0;
      red_d  = '0;
      grn_d  = '0;
      for (int r = 0; r < ROWS; r++) begin
         gate_d[r]   = pattern_q[r][step_idx] & ~mute[r];
         red_d[r][0] = mute[r];
         for (int s = 0; s < STEPS; s++) begin
            grn_d[r][DISP_DIM-1-s] = pattern_q[r][s];
            if (sel_ok && int'(note_sel) == r && int'(step_idx) == s)
               red_d[r][DISP_DIM-1-s] = 1'b1;
         end
      end
   end

   // State, pattern storage and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         clr_row_q <= '0;
         // NOTE: the pattern is a small flop array, so reset clears it like any other state.
         pattern_q <= '0;
         gate_q    <= '0;
         red_q     <= '0;
         grn_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_row_q <= clr_row_d;
         pattern_q <= pattern_d;
         gate_q    <= gate_d;
         red_q     <= red_d;
         grn_q     <= grn_d;
      end
   end

   assign gate_out  = gate_q;
   assign RedPixels = red_q;
   assign GrnPixels = grn_q;

endmodule

// File: tb/tb_step_sequencer_grid.sv
// Directed bench for step_sequencer_grid with hand-computed expectations.
module tb_step_sequencer_grid;
   import seq_grid_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic [10:0]  pos;
   logic [2:0]   note_sel;
   logic         write;
   logic         erase;
   logic         clear_req;
   logic [7:0]   mute;
   logic         busy;
   logic [7:0]   gate_out;
   logic [3:0]   step_idx;
   logic         step_tick;
   pixel_frame_t RedPixels;
   pixel_frame_t GrnPixels;

   int           checks = 0;
   int           errors = 0;
   int           n;
   pixel_frame_t exp_red;
   pixel_frame_t exp_grn;

   step_sequencer_grid dut (
      .clk       (clk),
      .reset     (reset),
      .pos       (pos),
      .note_sel  (note_sel),
      .write     (write),
      .erase     (erase),
      .clear_req (clear_req),
      .mute      (mute),
      .busy      (busy),
      .gate_out  (gate_out),
      .step_idx  (step_idx),
      .step_tick (step_tick),
      .RedPixels (RedPixels),
      .GrnPixels (GrnPixels)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int cycles = 1);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with write asserted: nothing may stick.
      reset = 1'b0; pos = 11'd500; note_sel = 3'd0; write = 1'b1;
      erase = 1'b0; clear_req = 1'b0; mute = 8'h00;
      tick(3);
      check("rst_busy", busy, 1'b0);
      check("rst_gate", gate_out, 8'h00);
      check("rst_step", step_idx, 4'd0);
      check("rst_tick", step_tick, 1'b0);
      check("rst_red", RedPixels, '0);
      check("rst_grn", GrnPixels, '0);

      // First cycle after reset moves to step 3 without a tick.
      reset = 1'b1; write = 1'b0;
      tick();
      check("first_step", step_idx, 4'd3);
      check("first_no_tick", step_tick, 1'b0);

      // Quantisation and tick behaviour.
      pos = 11'd0;    tick();
      check("q0_step", step_idx, 4'd0);
      check("q0_tick", step_tick, 1'b1);
      pos = 11'd145;  tick();
      check("q145_step", step_idx, 4'd0);
      check("q145_tick", step_tick, 1'b0);
      pos = 11'd146;  tick();
      check("q146_step", step_idx, 4'd1);
      check("q146_tick", step_tick, 1'b1);
      tick();
      check("hold_tick", step_tick, 1'b0);
      pos = 11'd2047; tick();
      check("q2047_clamp", step_idx, 4'd14);
      check("q2047_tick", step_tick, 1'b1);

      // Record at step 2 on row 3, then erase-and-write together clears it.
      pos = 11'd292; note_sel = 3'd3; tick();
      check("rec_step", step_idx, 4'd2);
      write = 1'b1; tick();
      write = 1'b0; tick();
      exp_grn = '0; exp_grn[3][13] = 1'b1;
      exp_red = '0; exp_red[3][13] = 1'b1;
      check("rec_grn", GrnPixels, exp_grn);
      check("rec_gate", gate_out, 8'h08);
      check("rec_cursor", RedPixels, exp_red);
      erase = 1'b1; write = 1'b1; tick();
      erase = 1'b0; write = 1'b0; tick();
      check("erase_grn", GrnPixels, '0);
      check("erase_gate", gate_out, 8'h00);

      // Mute row 2 at step 5: stored but silent, indicator lit.
      pos = 11'd730; note_sel = 3'd2; tick();
      check("mute_step", step_idx, 4'd5);
      write = 1'b1; tick();
      write = 1'b0; mute = 8'h04; tick();
      exp_red = '0; exp_red[2][10] = 1'b1; exp_red[2][0] = 1'b1;
      exp_grn = '0; exp_grn[2][10] = 1'b1;
      check("mute_gate", gate_out, 8'h00);
      check("mute_red", RedPixels, exp_red);
      check("mute_grn", GrnPixels, exp_grn);
      mute = 8'h00; tick();
      check("unmute_gate", gate_out, 8'h04);

      // Fill every row at step 5, then sweep-clear with writes attempted while busy.
      for (int r = 0; r < 8; r++) begin
         note_sel = 3'(r); write = 1'b1; tick();
      end
      write = 1'b0; tick();
      exp_grn = '0;
      for (int r = 0; r < 8; r++) exp_grn[r][10] = 1'b1;
      check("fill_grn", GrnPixels, exp_grn);
      check("fill_gate", gate_out, 8'hff);
      clear_req = 1'b1; tick();
      clear_req = 1'b0;
      check("clr_busy", busy, 1'b1);
      write = 1'b1; note_sel = 3'd0; pos = 11'd876;
      n = 0;
      while (busy && n < 20) begin
         n++;
         tick();
      end
      write = 1'b0;
      check("clr_busy_cycles", n, 8);
      check("clr_playback_step", step_idx, 4'd6);
      tick();
      check("clr_grn", GrnPixels, '0);
      check("clr_gate", gate_out, 8'h00);

      // Reset in the middle of a sweep aborts it and leaves an empty pattern.
      note_sel = 3'd5; write = 1'b1; tick();
      note_sel = 3'd7; tick();
      write = 1'b0; tick();
      exp_grn = '0; exp_grn[5][9] = 1'b1; exp_grn[7][9] = 1'b1;
      check("refill_grn", GrnPixels, exp_grn);
      clear_req = 1'b1; tick();
      clear_req = 1'b0; tick();
      check("mid_busy", busy, 1'b1);
      reset = 1'b0; tick();
      reset = 1'b1;
      check("abort_busy", busy, 1'b0);
      check("abort_grn", GrnPixels, '0);
      tick(2);
      check("post_abort_busy", busy, 1'b0);
      check("post_abort_grn", GrnPixels, '0);

      // Wrap from step 13 back to step 0; cursor moves to column 15.
      pos = 11'd2000; note_sel = 3'd1; tick();
      check("wrap_pre_step", step_idx, 4'd13);
      check("wrap_pre_tick", step_tick, 1'b1);
      pos = 11'd0; tick();
      check("wrap_step", step_idx, 4'd0);
      check("wrap_tick", step_tick, 1'b1);
      tick();
      exp_red = '0; exp_red[1][15] = 1'b1;
      check("wrap_tick_low", step_tick, 1'b0);
      check("wrap_cursor", RedPixels, exp_red);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
